// File: rtl/inst_dispatch_pkg.sv
// Shared definitions for the multi-engine instruction dispatcher: opcodes,
// FSM state encoding and instruction field offsets.
package inst_dispatch_pkg;

  localparam int OP_COMP     = 0;
  localparam int OP_DMA_BASE = 1;

  // Instruction layout, LSB first: {payload, dep, type}.
  localparam int TYPE_LSB = 0;

  function automatic int dep_lsb(input int type_w);
    return TYPE_LSB + type_w;
  endfunction

  function automatic int payload_lsb(input int type_w, input int dep_w);
    return TYPE_LSB + type_w + dep_w;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ISSUE,
    S_GAP
  } state_t;

endpackage

// File: rtl/inst_dispatch_mc_dep_check.sv
// Combinational readiness check: the target engine class must be free and
// every engine named in the dependency mask must be idle.
module dep_check
  import inst_dispatch_pkg::*;
#(
  parameter int TYPE_W  = 4,
  parameter int NUM_DMA = 4,
  parameter int DEP_W   = 8
) (
  input  logic [TYPE_W-1:0]  op,
  input  logic [DEP_W-1:0]   dep,
  input  logic               comp_idle,
  input  logic [NUM_DMA-1:0] dma_idle,
  output logic               ready
);

  // Mask positions above the compute bit read as permanently idle.
  localparam logic [DEP_W-1:0] IGNORE_MASK = ~DEP_W'((1 << (NUM_DMA + 1)) - 1);

  logic [DEP_W-1:0] idle_vec;
  logic             deps_ok;
  logic             target_ok;

  assign idle_vec  = DEP_W'({comp_idle, dma_idle}) | IGNORE_MASK;
  assign deps_ok   = &(~dep | idle_vec);
  // All DMA engines share one DDR port, so any DMA issue needs every engine idle.
  assign target_ok = (op == TYPE_W'(OP_COMP)) ? comp_idle : &dma_idle;
  assign ready     = deps_ok & target_ok;

endmodule

// File: rtl/inst_dispatch_mc.sv
// Instruction dispatcher for one compute engine and NUM_DMA DDR engines.
// Optional perf counters are enabled by defining INST_DISPATCH_PERF_CNT_EN.
module inst_dispatch_mc
  import inst_dispatch_pkg::*;
#(
  parameter int INST_LEN  = 220,
  parameter int TYPE_W    = 4,
  parameter int NUM_DMA   = 4,
  parameter int DEP_W     = 8,
  parameter int SW_W      = 2,
  parameter int PAYLOAD_W = INST_LEN - TYPE_W - DEP_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INST_LEN-1:0]  instruct,
  input  logic                 inst_empty,
  output logic                 inst_req,
  input  logic                 comp_idle,
  output logic                 comp_conf,
  input  logic [NUM_DMA-1:0]   dma_idle,
  input  logic [NUM_DMA-1:0]   dma_wr,
  output logic [NUM_DMA-1:0]   dma_conf,
  output logic [PAYLOAD_W-1:0] payload,
  output logic [SW_W-1:0]      switch,
  output logic                 mig_type,
  output logic                 err_illegal,
  output logic                 busy
`ifdef INST_DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]          stall_cycles,
  output logic [31:0]          issue_count
`endif
);

  localparam int DEP_LSB = dep_lsb(TYPE_W);
  localparam int PAY_LSB = payload_lsb(TYPE_W, DEP_W);

  state_t                state, state_n;
  logic [INST_LEN-1:0]   inst_q;
  logic [TYPE_W-1:0]     op_q;
  logic [DEP_W-1:0]      dep_q;
  logic [PAYLOAD_W-1:0]  pay_q;
  logic                  legal, is_comp, ready, issue, wr_sel;
  logic [NUM_DMA-1:0]    dma_hot;
  logic [SW_W-1:0]       sw_next;

  assign op_q  = inst_q[TYPE_LSB +: TYPE_W];
  assign dep_q = inst_q[DEP_LSB +: DEP_W];
  assign pay_q = inst_q[PAY_LSB +: PAYLOAD_W];

  assign legal   = op_q <= TYPE_W'(NUM_DMA);
  assign is_comp = op_q == TYPE_W'(OP_COMP);
  assign issue   = (state == S_WAIT) && legal && ready;
  assign sw_next = SW_W'(op_q - TYPE_W'(OP_DMA_BASE));
  assign wr_sel  = |(dma_hot & dma_wr);
  assign busy    = state != S_IDLE;

  always_comb begin
    dma_hot = '0;
    for (int k = 0; k < NUM_DMA; k++)
      dma_hot[k] = (op_q == TYPE_W'(OP_DMA_BASE + k));
  end

  dep_check #(
    .TYPE_W  (TYPE_W),
    .NUM_DMA (NUM_DMA),
    .DEP_W   (DEP_W)
  ) u_dep_check (
    .op        (op_q),
    .dep       (dep_q),
    .comp_idle (comp_idle),
    .dma_idle  (dma_idle),
    .ready     (ready)
  );

  // NOTE: inst_q is a pure data holder, always written in S_IDLE before it is
  // decoded, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && !inst_empty) inst_q <= instruct;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every always_ff reads the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // NOTE: next state defaults to the current state before the case so no
  // path leaves state_n unassigned and no latch is inferred.
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (!inst_empty) state_n = S_WAIT;
      S_WAIT: begin
        if (!legal)     state_n = S_GAP;
        else if (ready) state_n = S_ISSUE;
      end
      S_ISSUE: state_n = S_GAP;
      S_GAP:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Pulses are registered on the WAIT decision so they appear in S_ISSUE/S_GAP.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      comp_conf   <= 1'b0;
      dma_conf    <= '0;
      inst_req    <= 1'b0;
      payload     <= '0;
      switch      <= '0;
      mig_type    <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      comp_conf <= 1'b0;
      dma_conf  <= '0;
      inst_req  <= 1'b0;
      if (state == S_WAIT && !legal) begin
        err_illegal <= 1'b1;
        inst_req    <= 1'b1;
      end else if (issue) begin
        inst_req <= 1'b1;
        payload  <= pay_q;
        if (is_comp) begin
          comp_conf <= 1'b1;
        end else begin
          dma_conf <= dma_hot;
          mig_type <= wr_sel;
          // Write engines do not use the read mux; keep it where it was.
          if (!wr_sel) switch <= sw_next;
        end
      end
    end
  end

`ifdef INST_DISPATCH_PERF_CNT_EN
  logic stall;
  assign stall = (state == S_WAIT) && legal && !ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      issue_count  <= '0;
    end else begin
      if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
      if (issue && issue_count  != '1) issue_count  <= issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_dispatch_mc.sv
// Self-checking bench for inst_dispatch_mc: directed table, multi-cycle
// corner sequences, then randomized traffic against a timestamp model.
module tb_inst_dispatch_mc;

  localparam int INST_LEN  = 220;
  localparam int TYPE_W    = 4;
  localparam int NUM_DMA   = 4;
  localparam int DEP_W     = 8;
  localparam int SW_W      = 2;
  localparam int PAYLOAD_W = INST_LEN - TYPE_W - DEP_W;
  localparam int PL        = TYPE_W + DEP_W;

  logic                 clk;
  logic                 rst_n;
  logic [INST_LEN-1:0]  instruct;
  logic                 inst_empty;
  logic                 inst_req;
  logic                 comp_idle;
  logic                 comp_conf;
  logic [NUM_DMA-1:0]   dma_idle;
  logic [NUM_DMA-1:0]   dma_wr;
  logic [NUM_DMA-1:0]   dma_conf;
  logic [PAYLOAD_W-1:0] payload;
  logic [SW_W-1:0]      switch;
  logic                 mig_type;
  logic                 err_illegal;
  logic                 busy;
`ifdef INST_DISPATCH_PERF_CNT_EN
  logic [31:0]          stall_cycles;
  logic [31:0]          issue_count;
`endif

  inst_dispatch_mc #(
    .INST_LEN (INST_LEN),
    .TYPE_W   (TYPE_W),
    .NUM_DMA  (NUM_DMA),
    .DEP_W    (DEP_W),
    .SW_W     (SW_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruct    (instruct),
    .inst_empty  (inst_empty),
    .inst_req    (inst_req),
    .comp_idle   (comp_idle),
    .comp_conf   (comp_conf),
    .dma_idle    (dma_idle),
    .dma_wr      (dma_wr),
    .dma_conf    (dma_conf),
    .payload     (payload),
    .switch      (switch),
    .mig_type    (mig_type),
    .err_illegal (err_illegal),
    .busy        (busy)
`ifdef INST_DISPATCH_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles),
    .issue_count  (issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [INST_LEN-1:0] make_inst(input logic [TYPE_W-1:0] op,
                                                    input logic [DEP_W-1:0] dep,
                                                    input logic [PAYLOAD_W-1:0] pay);
    return {pay, dep, op};
  endfunction

  function automatic logic [PAYLOAD_W-1:0] rand_pay();
    logic [223:0] r;
    for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
    return r[PAYLOAD_W-1:0];
  endfunction

  // Readiness from the rules: the target class is free and every engine the
  // mask names (DMA 0..NUM_DMA-1, compute at NUM_DMA) is idle.
  function automatic bit model_ready(input int op, input logic [DEP_W-1:0] dep,
                                     input logic cidle, input logic [NUM_DMA-1:0] didle);
    logic [NUM_DMA:0] eng;
    bit ok;
    eng = {cidle, didle};
    ok  = (op == 0) ? bit'(cidle) : (didle == {NUM_DMA{1'b1}});
    for (int e = 0; e <= NUM_DMA; e++)
      if (dep[e] && !eng[e]) ok = 0;
    return ok;
  endfunction

  typedef struct {
    logic [TYPE_W-1:0]  op;
    logic [DEP_W-1:0]   dep;
    logic [NUM_DMA-1:0] wr;
    logic               cidle;
    logic [NUM_DMA-1:0] didle;
    logic               e_comp;
    logic [NUM_DMA-1:0] e_dma;
    logic [SW_W-1:0]    e_sw;
    logic               e_mig;
    logic               e_err;
  } vec_t;

  vec_t vecs[10];

  // Random-phase model state
  logic [INST_LEN-1:0]  q[$];
  bit                   have;
  logic [INST_LEN-1:0]  cur;
  int                   free_at;
  logic                 e_comp, e_req, e_mig, e_err, e_busy, req_last;
  logic [NUM_DMA-1:0]   e_dma;
  logic [PAYLOAD_W-1:0] e_pay;
  logic [SW_W-1:0]      e_sw;
  longint               e_stall, e_issue;

  initial begin
    logic [PAYLOAD_W-1:0] pay, last_pay;
    vec_t v;

    //            op     dep     wr       ci    di       comp  dma      sw    mig   err
    vecs[0] = '{4'd0,  8'h00, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[1] = '{4'd3,  8'h00, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b0, 1'b0};
    vecs[2] = '{4'd4,  8'h00, 4'b1000, 1'b0, 4'b1111, 1'b0, 4'b1000, 2'd2, 1'b1, 1'b0};
    vecs[3] = '{4'd1,  8'h00, 4'b1000, 1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b0, 1'b0};
    vecs[4] = '{4'd0,  8'hE0, 4'b0000, 1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
    vecs[5] = '{4'd2,  8'h10, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0010, 2'd1, 1'b0, 1'b0};
    vecs[6] = '{4'd0,  8'h0F, 4'b0000, 1'b1, 4'b1111, 1'b1, 4'b0000, 2'd1, 1'b0, 1'b0};
    vecs[7] = '{4'd9,  8'h00, 4'b0000, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd1, 1'b0, 1'b1};
    vecs[8] = '{4'd4,  8'h00, 4'b1000, 1'b1, 4'b1111, 1'b0, 4'b1000, 2'd1, 1'b1, 1'b1};
    vecs[9] = '{4'd15, 8'h00, 4'b1000, 1'b1, 4'b1111, 1'b0, 4'b0000, 2'd1, 1'b1, 1'b1};

    rst_n = 1'b0; inst_empty = 1'b1; instruct = '0;
    comp_idle = 1'b1; dma_idle = '1; dma_wr = '0;
    repeat (3) @(negedge clk);
    check("rst_comp_conf", comp_conf, 0);
    check("rst_dma_conf", dma_conf, 0);
    check("rst_inst_req", inst_req, 0);
    check("rst_payload", payload, 0);
    check("rst_switch", switch, 0);
    check("rst_mig_type", mig_type, 0);
    check("rst_err", err_illegal, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    last_pay = '0;

    // Directed table: head valid at t, decision visible at t+2
    for (int i = 0; i < 10; i++) begin
      v = vecs[i];
      @(negedge clk);
      dma_wr = v.wr; comp_idle = v.cidle; dma_idle = v.didle;
      pay = rand_pay();
      instruct = make_inst(v.op, v.dep, pay);
      inst_empty = 1'b0;
      @(negedge clk);
      check("tbl_wait_busy", busy, 1);
      check("tbl_wait_noconf", {comp_conf, dma_conf, inst_req}, 0);
      @(negedge clk);
      if (v.e_comp || (v.e_dma != 0)) last_pay = pay;
      check("tbl_comp_conf", comp_conf, v.e_comp);
      check("tbl_dma_conf", dma_conf, v.e_dma);
      check("tbl_inst_req", inst_req, 1);
      check("tbl_payload", payload, last_pay);
      check("tbl_switch", switch, v.e_sw);
      check("tbl_mig_type", mig_type, v.e_mig);
      check("tbl_err", err_illegal, v.e_err);
      inst_empty = 1'b1;
      @(negedge clk);
      check("tbl_pulse_end", {comp_conf, dma_conf, inst_req}, 0);
      @(negedge clk);
      check("tbl_back_idle", busy, 0);
    end

    // Reset while stalled in S_WAIT: instruction survives and reissues
    @(negedge clk);
    pay = rand_pay();
    instruct = make_inst(4'd3, 8'h01, pay);
    dma_wr = '0; comp_idle = 1'b1; dma_idle = 4'b1110; inst_empty = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rw_stalled", {busy, inst_req, comp_conf, dma_conf}, {1'b1, 6'b0});
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("rw_rst_pulses", {comp_conf, dma_conf, inst_req}, 0);
    check("rw_rst_payload", payload, 0);
    check("rw_rst_switch", switch, 0);
    check("rw_rst_mig", mig_type, 0);
    check("rw_rst_err", err_illegal, 0);
    check("rw_rst_busy", busy, 0);
    rst_n = 1'b1; dma_idle = '1;
    @(negedge clk);
    check("rw_relatch", {busy, inst_req}, 2'b10);
    @(negedge clk);
    check("rw_dma_conf", dma_conf, 4'b0100);
    check("rw_inst_req", inst_req, 1);
    check("rw_payload", payload, pay);
    check("rw_switch", switch, 2);
    check("rw_mig", mig_type, 0);
    inst_empty = 1'b1;
    @(negedge clk);
    check("rw_pulse_end", {dma_conf, inst_req}, 0);

    // Dependency stall: compute waits 20 cycles on DMA engine 0
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    pay = rand_pay();
    instruct = make_inst(4'd0, 8'h01, pay);
    comp_idle = 1'b1; dma_idle = 4'b1110; inst_empty = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("dep_hold", {comp_conf, inst_req}, 0);
    end
    @(negedge clk);
    dma_idle = '1;
    check("dep_release_cycle", comp_conf, 0);
    @(negedge clk);
    check("dep_comp_conf", comp_conf, 1);
    check("dep_inst_req", inst_req, 1);
    check("dep_payload", payload, pay);
`ifdef INST_DISPATCH_PERF_CNT_EN
    check("dep_stall_cycles", stall_cycles, 20);
`endif
    inst_empty = 1'b1;
    @(negedge clk);
    check("dep_pulse_end", {comp_conf, inst_req}, 0);
`ifdef INST_DISPATCH_PERF_CNT_EN
    check("dep_issue_count", issue_count, 1);
`endif

    // Randomized traffic against a timestamp model: latch at n, decide at
    // n+1, pulses one cycle after the decision, free 3 (issue) or 2 (illegal)
    // cycles after it.
    dma_wr = 4'b1010;
    have = 0; free_at = 0; req_last = 0;
    e_comp = 0; e_dma = '0; e_req = 0; e_pay = '0; e_sw = '0; e_mig = 0; e_err = 0; e_busy = 0;
    e_stall = 0; e_issue = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (n > 0) begin
        check("rnd_comp_conf", comp_conf, e_comp);
        check("rnd_dma_conf", dma_conf, e_dma);
        check("rnd_inst_req", inst_req, e_req);
        check("rnd_payload", payload, e_pay);
        check("rnd_switch", switch, e_sw);
        check("rnd_mig_type", mig_type, e_mig);
        check("rnd_err", err_illegal, e_err);
        check("rnd_busy", busy, e_busy);
`ifdef INST_DISPATCH_PERF_CNT_EN
        check("rnd_stall_cycles", stall_cycles, 32'(e_stall));
        check("rnd_issue_count", issue_count, 32'(e_issue));
`endif
      end
      if (req_last) void'(q.pop_front());
      req_last = e_req;
      if (q.size() < 4 && ($urandom % 3) == 0) begin
        logic [TYPE_W-1:0] op;
        op = (($urandom % 8) == 0) ? TYPE_W'(5 + $urandom % 11) : TYPE_W'($urandom % 5);
        q.push_back(make_inst(op, DEP_W'($urandom & $urandom & $urandom), rand_pay()));
      end
      inst_empty = (q.size() == 0);
      instruct   = inst_empty ? {7{$urandom}} : q[0];
      comp_idle  = ($urandom % 4) != 0;
      for (int k = 0; k < NUM_DMA; k++) dma_idle[k] = ($urandom % 6) != 0;
      rst_n = (n == 0 || ($urandom % 250) == 0) ? 1'b0 : 1'b1;

      e_comp = 0; e_dma = '0; e_req = 0;
      if (!rst_n) begin
        have = 0; free_at = n + 1;
        e_pay = '0; e_sw = '0; e_mig = 0; e_err = 0; e_stall = 0; e_issue = 0;
      end else if (!have) begin
        if (n >= free_at && q.size() > 0) begin
          have = 1; cur = q[0];
        end
      end else begin
        int op;
        op = int'(cur[TYPE_W-1:0]);
        if (op > NUM_DMA) begin
          e_err = 1; e_req = 1; have = 0; free_at = n + 2;
        end else if (model_ready(op, cur[PL-1:TYPE_W], comp_idle, dma_idle)) begin
          e_req = 1; e_pay = cur[INST_LEN-1:PL];
          if (op == 0) e_comp = 1;
          else begin
            e_dma = NUM_DMA'(1 << (op - 1));
            e_mig = dma_wr[op-1];
            if (!e_mig) e_sw = SW_W'(op - 1);
          end
          have = 0; free_at = n + 3;
          if (e_issue < 64'hFFFF_FFFF) e_issue++;
        end else begin
          if (e_stall < 64'hFFFF_FFFF) e_stall++;
        end
      end
      e_busy = rst_n && (have || (n + 1 < free_at));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_dispatch_mc.md
Name: inst_dispatch_mc

Overview:
- Parametrised successor to the single-FIFO instruction controller: decodes instructions from a show-ahead instruction FIFO and issues them to one compute engine plus NUM_DMA DDR transfer engines (weight/bias/data load, write-back, ...).
- Uses an explicit FSM and per-instruction dependency masks instead of hardwired type checks.
- Generates one-cycle conf pulses, FIFO pop pulses and DDR-mux select (switch/mig_type).
- Flags illegal opcodes rather than hanging.

Parameters:
- INST_LEN, 220, instruction width in bits.
- TYPE_W, 4, opcode field width, bits [TYPE_W-1:0].
- NUM_DMA, 4, number of DDR transfer engines (1..8).
- DEP_W, 8, dependency mask width: bit k<NUM_DMA = DMA engine k, bit NUM_DMA = compute engine.
- SW_W, 2, DDR read-mux select width; must hold NUM_DMA-1.
- PAYLOAD_W, INST_LEN-TYPE_W-DEP_W, payload width forwarded to engines.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- instruct  in  INST_LEN  FIFO head: {payload, dep[DEP_W-1:0], type[TYPE_W-1:0]}; valid when inst_empty=0.
- inst_empty  in  1  FIFO empty.
- inst_req  out  1  one-cycle pop pulse.
- comp_idle  in  1  compute engine idle.
- comp_conf  out  1  one-cycle compute start.
- dma_idle  in  NUM_DMA  per-engine idle.
- dma_wr  in  NUM_DMA  static: engine k is a DDR write engine.
- dma_conf  out  NUM_DMA  one-hot one-cycle start pulse.
- payload  out  PAYLOAD_W  registered payload; stable from conf until the next issue.
- switch  out  SW_W  DDR read-mux select.
- mig_type  out  1  0=DDR read, 1=DDR write.
- err_illegal  out  1  sticky illegal-opcode flag.
- busy  out  1  FSM not in S_IDLE.

Behaviour:
- Reset, synchronous on rst_n=0 (including mid-issue): all conf pulses, inst_req, payload, switch, mig_type, err_illegal, busy = 0; FSM = S_IDLE. A pending instruction is not popped and is re-decoded after reset.
- Opcodes:
  - 0: compute.
  - 1..NUM_DMA: DMA engine type-1.
  - Others: illegal.
- FSM states:
  - S_IDLE: if !inst_empty, latch instruct into inst_q and go to S_WAIT.
  - S_WAIT:
    - Illegal opcode: set err_illegal, pulse inst_req, go to S_GAP. No conf is issued.
    - Ready (see below): go to S_ISSUE. Otherwise stay in S_WAIT indefinitely; there is no timeout.
    - Ready for compute: comp_idle=1, and every set dep bit's engine is idle.
    - Ready for DMA: all dma_idle=1 (shared DDR port), and every set dep bit's engine is idle.
  - S_ISSUE, one cycle:
    - Drive exactly one conf bit and inst_req=1.
    - Load payload.
    - For DMA: switch = type-1 when dma_wr=0, else switch holds; mig_type = dma_wr[type-1].
    - For compute: switch and mig_type hold.
    - Go to S_GAP.
  - S_GAP, one cycle: lets the FIFO head advance and the engine drop idle. Engines must deassert idle the cycle after conf. Then go to S_IDLE.
- Latency: head valid at cycle t → earliest conf/inst_req at t+2. Back-to-back issue interval is 4 cycles minimum.
- inst_req and the conf bit rise on the same edge and are never asserted two consecutive cycles.
- Dep bits at positions ≥ NUM_DMA+1 are ignored.
- inst_empty rising while in S_WAIT is a FIFO protocol violation; inst_q is used regardless.
- err_illegal clears only on reset.

Optional Feature:
- Macro: INST_DISPATCH_PERF_CNT_EN.
- When defined: adds output stall_cycles[31:0] and output issue_count[31:0].
  - stall_cycles increments each cycle in S_WAIT where not ready.
  - issue_count increments on each conf.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined: neither port nor any counter logic exists.

Decomposition:
- Package inst_dispatch_pkg:
  - Opcode constants OP_COMP=0, OP_DMA_BASE=1.
  - FSM state enum (S_IDLE, S_WAIT, S_ISSUE, S_GAP).
  - Field offset localparams for type, dep and payload.
- One sub-module dep_check: combinational ready = f(type, dep, comp_idle, dma_idle). It is isolated so the readiness logic can be unit-tested.

Test Plan:
- Compute issue: type=0, dep=0, comp_idle=1, head valid at cycle 10 → comp_conf and inst_req high at cycle 12 only; payload equals instruct[INST_LEN-1:12].
- DMA read k=2: type=3, dma_wr=0, all idle → dma_conf=4'b0100, switch=2, mig_type=0 at t+2.
- DMA write: type=4, dma_wr=4'b1000 → dma_conf=4'b1000, mig_type=1, switch unchanged from the previous value.
- Dependency stall: type=0, dep bit0 set, dma_idle[0]=0 for 20 cycles → no conf while held. After dma_idle[0]=1, comp_conf follows 1 cycle later. With the macro defined, stall_cycles=20.
- Illegal op: type=9 with NUM_DMA=4 → inst_req pulse, no conf, err_illegal=1. The next valid instruction still issues.
- Reset mid-wait: rst_n=0 for 1 cycle while in S_WAIT → all outputs 0. The instruction is not popped; it issues normally after reset with the same payload.
